// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, LCD command bytes and init list for the phrase writer
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    LINE_CMD,
    FETCH,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    SETUP,
    EN_HIGH,
    WAIT
  } strobe_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  // Entry 0 is issued first; the clear must stay last so its long wait ends init.
  localparam int INIT_LEN = 4;
  localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 1);
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {CMD_CLEAR, CMD_ENTRY, CMD_DISP_ON, CMD_FUNC_SET};

  function automatic logic is_clear(input logic rs, input logic [7:0] b);
    return (!rs) && (b == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/lcd_phrase_writer_if.sv
// rtl/lcd_phrase_writer_if.sv - phrase ROM, LCD pin and control signals of the phrase writer
interface lcd_phrase_writer_if;

  logic       start;
  logic [4:0] rom_addr;
  logic [7:0] rom_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       busy;
  logic       done;

  modport master (
    input  start, rom_data,
    output rom_addr, lcd_rs, lcd_rw, lcd_en, lcd_data, busy, done
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, lcd_rs, lcd_rw, lcd_en, lcd_data, busy, done
  );

endinterface

// File: rtl/lcd_strobe.sv
// rtl/lcd_strobe.sv - one LCD bus transfer: setup cycle, enable pulse, post-transfer wait
module lcd_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned EN_PULSE_CYCLES   = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic [7:0] tx_byte,
  input  logic       tx_rs,
  input  logic       long_wait,
  output logic       ack,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  strobe_state_t st, st_d;
  logic [31:0]   cnt, cnt_d;
  logic [31:0]   wait_last;
  logic          long_q, long_q_d;
  logic          en_d, rs_d;
  logic [7:0]    data_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      st       <= st_d;
      cnt      <= cnt_d;
      long_q   <= long_q_d;
      lcd_en   <= en_d;
      lcd_rs   <= rs_d;
      lcd_data <= data_d;
    end
  end

  // Data and rs only load on acceptance, so they hold through the pulse and the whole wait.
  always_comb begin
    st_d      = st;
    cnt_d     = cnt;
    long_q_d  = long_q;
    en_d      = lcd_en;
    rs_d      = lcd_rs;
    data_d    = lcd_data;
    ack       = 1'b0;
    wait_last = long_q ? (CLEAR_WAIT_CYCLES - 1) : (CMD_WAIT_CYCLES - 1);
    case (st)
      ST_IDLE: begin
        if (req) begin
          data_d   = tx_byte;
          rs_d     = tx_rs;
          long_q_d = long_wait;
          st_d     = SETUP;
        end
      end
      SETUP: begin
        en_d  = 1'b1;
        cnt_d = '0;
        st_d  = EN_HIGH;
      end
      EN_HIGH: begin
        if (cnt == EN_PULSE_CYCLES - 1) begin
          en_d  = 1'b0;
          cnt_d = '0;
          st_d  = WAIT;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      WAIT: begin
        if (cnt == wait_last) begin
          ack   = 1'b1;
          cnt_d = '0;
          st_d  = ST_IDLE;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/lcd_phrase_writer.sv
// rtl/lcd_phrase_writer.sv - runs LCD init, then copies the 32-byte phrase ROM onto both lines per start
module lcd_phrase_writer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned EN_PULSE_CYCLES   = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic                clock,
  input  logic                reset_n,
  lcd_phrase_writer_if.master bus
);

  state_t      state, state_d;
  logic [31:0] pcnt, pcnt_d;
  logic [1:0]  init_idx, init_idx_d;
  logic [4:0]  char_idx, char_idx_d;
  logic        fetch_ready, fetch_ready_d;
  logic        busy_q, done_q;
  logic [4:0]  rom_addr_q;

  logic        req, tx_rs, long_wait, ack;
  logic [7:0]  tx_byte;
  logic        lcd_rs, lcd_en;
  logic [7:0]  lcd_data;

  lcd_strobe #(
    .EN_PULSE_CYCLES  (EN_PULSE_CYCLES),
    .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_strobe (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .tx_byte  (tx_byte),
    .tx_rs    (tx_rs),
    .long_wait(long_wait),
    .ack      (ack),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.lcd_rs   = lcd_rs;
  assign bus.lcd_en   = lcd_en;
  assign bus.lcd_data = lcd_data;
  assign bus.lcd_rw   = 1'b0;

  // busy/done/rom_addr are registered from next-state values so they line up with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= POWERUP;
      pcnt        <= '0;
      init_idx    <= '0;
      char_idx    <= '0;
      fetch_ready <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      state       <= state_d;
      pcnt        <= pcnt_d;
      init_idx    <= init_idx_d;
      char_idx    <= char_idx_d;
      fetch_ready <= fetch_ready_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      rom_addr_q  <= char_idx_d;
    end
  end

  always_comb begin
    state_d       = state;
    pcnt_d        = pcnt;
    init_idx_d    = init_idx;
    char_idx_d    = char_idx;
    fetch_ready_d = fetch_ready;
    req           = 1'b0;
    tx_byte       = 8'h00;
    tx_rs         = 1'b0;
    case (state)
      POWERUP: begin
        if (pcnt == POWERUP_CYCLES - 1) begin
          pcnt_d     = '0;
          init_idx_d = '0;
          state_d    = INIT;
        end else begin
          pcnt_d = pcnt + 32'd1;
        end
      end
      INIT: begin
        req     = 1'b1;
        tx_byte = INIT_CMDS[init_idx];
        if (ack) begin
          if (init_idx == INIT_LAST) state_d = IDLE;
          else init_idx_d = init_idx + 2'd1;
        end
      end
      IDLE: begin
        if (bus.start) begin
          char_idx_d = '0;
          state_d    = LINE_CMD;
        end
      end
      LINE_CMD: begin
        req     = 1'b1;
        tx_byte = (char_idx == 5'd0) ? CMD_LINE1 : CMD_LINE2;
        if (ack) begin
          fetch_ready_d = 1'b0;
          state_d       = FETCH;
        end
      end
      FETCH: begin
        // First cycle lets the ROM register rom_addr; rom_data is valid on the second.
        if (fetch_ready) begin
          req     = 1'b1;
          tx_byte = bus.rom_data;
          tx_rs   = 1'b1;
        end else begin
          fetch_ready_d = 1'b1;
        end
        if (ack) begin
          fetch_ready_d = 1'b0;
          char_idx_d    = char_idx + 5'd1;
          if (char_idx == 5'd15)      state_d = LINE_CMD;
          else if (char_idx == 5'd31) state_d = DONE;
          else                        state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = POWERUP;
      end
    endcase
    long_wait = is_clear(tx_rs, tx_byte);
  end

endmodule

// File: tb/tb_lcd_phrase_writer.sv
// tb/tb_lcd_phrase_writer.sv - randomized self-checking bench for lcd_phrase_writer
module tb_lcd_phrase_writer;

  localparam int unsigned P_POWERUP = 20;
  localparam int unsigned P_EN      = 3;
  localparam int unsigned P_CMD     = 10;
  localparam int unsigned P_CLEAR   = 40;
  localparam int          BUDGET    = 3000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  lcd_phrase_writer_if bus ();

  lcd_phrase_writer #(
    .POWERUP_CYCLES   (P_POWERUP),
    .EN_PULSE_CYCLES  (P_EN),
    .CMD_WAIT_CYCLES  (P_CMD),
    .CLEAR_WAIT_CYCLES(P_CLEAR)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] phrase [32];
  always @(posedge clock) bus.rom_data <= phrase[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] pulses [$];
  int         done_cnt;
  int         low_at_idle;
  logic       prev_en, prev_busy, have_prev, idle_since;
  logic [8:0] prev_val, rise_val, cur;
  int         width, low_cnt, req_wait;

  // Bus monitor: records {rs,data} per enable pulse and checks pulse shape and hold times.
  always @(negedge clock) begin
    cur = {bus.lcd_rs, bus.lcd_data};
    if (!reset_n) begin
      prev_en    = 1'b0;
      prev_busy  = 1'b0;
      have_prev  = 1'b0;
      idle_since = 1'b0;
      prev_val   = '0;
      width      = 0;
      low_cnt    = 0;
      req_wait   = 0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.lcd_en && !prev_en) begin
        check("setup_stable", 32'(cur), 32'(prev_val));
        check("rw_low", 32'(bus.lcd_rw), 0);
        if (have_prev && !idle_since) begin
          check("gap_min", 32'(low_cnt >= req_wait + 1), 1);
          check("gap_max", 32'(low_cnt <= req_wait + 6), 1);
        end
        pulses.push_back(cur);
        rise_val   = cur;
        width      = 1;
        idle_since = 1'b0;
      end else if (bus.lcd_en) begin
        check("hold_high", 32'(cur), 32'(rise_val));
        width++;
      end else if (prev_en) begin
        check("en_width", 32'(width), P_EN);
        check("hold_at_fall", 32'(cur), 32'(rise_val));
        req_wait  = (cur == 9'h001) ? int'(P_CLEAR) : int'(P_CMD);
        have_prev = 1'b1;
        low_cnt   = 1;
      end else begin
        if (have_prev && cur != prev_val) check("wait_hold", 32'(low_cnt >= req_wait), 1);
        if (prev_busy && !bus.busy) low_at_idle = low_cnt;
        if (!bus.busy) idle_since = 1'b1;
        low_cnt++;
      end
      prev_en   = bus.lcd_en;
      prev_val  = cur;
      prev_busy = bus.busy;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic release_and_init();
    logic [7:0] init_exp [4];
    int n;
    init_exp = '{8'h38, 8'h0C, 8'h06, 8'h01};
    pulses.delete();
    low_at_idle = -1;
    reset_n = 1'b1;
    tick();
    check("busy_after_release", 32'(bus.busy), 1);
    repeat (P_POWERUP - 1) tick();
    check("powerup_quiet", 32'(pulses.size()), 0);
    n = 0;
    while (bus.busy && n < BUDGET) begin
      tick();
      n++;
    end
    check("init_timeout", 32'(bus.busy), 0);
    check("init_count", 32'(pulses.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < pulses.size()) check("init_cmd", 32'(pulses[i]), 32'({1'b0, init_exp[i]}));
    check("clear_wait", 32'(low_at_idle), P_CLEAR);
  endtask

  // mode 0: plain refresh; 1: extra start once k pulses are out; 2: start during the done cycle
  task automatic run_refresh(input int mode, input int k);
    logic [8:0] exp_q [$];
    int n;
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, phrase[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, phrase[i]});
    pulses.delete();
    done_cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_on_start", 32'(bus.busy), 1);
    n = 0;
    if (mode == 1) begin
      while (pulses.size() < k && n < BUDGET) begin
        tick();
        n++;
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end else if (mode == 2) begin
      while (!bus.done && n < BUDGET) begin
        tick();
        n++;
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    while (bus.busy && n < BUDGET) begin
      tick();
      n++;
    end
    check("refresh_timeout", 32'(n < BUDGET), 1);
    repeat (5) tick();
    check("no_queued_start", 32'(bus.busy), 0);
    check("pulse_count", 32'(pulses.size()), 34);
    for (int i = 0; i < 34; i++)
      if (i < pulses.size()) check("refresh_pulse", 32'(pulses[i]), 32'(exp_q[i]));
    check("done_pulses", 32'(done_cnt), 1);
  endtask

  task automatic reset_mid();
    int n;
    pulses.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!(pulses.size() >= 12 && bus.lcd_en) && n < BUDGET) begin
      tick();
      n++;
    end
    check("midwrite_reach", 32'(n < BUDGET), 1);
    if (pulses.size() >= 12) check("midwrite_char10", 32'(pulses[11]), 32'({1'b1, phrase[10]}));
    #1 reset_n = 1'b0;
    #1;
    check("async_en", 32'(bus.lcd_en), 0);
    check("async_data", 32'(bus.lcd_data), 0);
    check("async_rs", 32'(bus.lcd_rs), 0);
    check("async_busy", 32'(bus.busy), 0);
    check("async_done", 32'(bus.done), 0);
    check("async_addr", 32'(bus.rom_addr), 0);
    repeat (2) tick();
  endtask

  initial begin
    string s1, s2;
    s1 = "0123456789ABCDEF";
    s2 = "abcdefghijklmnop";
    for (int i = 0; i < 16; i++) begin
      phrase[i]      = s1[i];
      phrase[16 + i] = s2[i];
    end
    bus.start = 1'b0;
    repeat (3) tick();
    check("rst_addr", 32'(bus.rom_addr), 0);
    check("rst_rs", 32'(bus.lcd_rs), 0);
    check("rst_rw", 32'(bus.lcd_rw), 0);
    check("rst_en", 32'(bus.lcd_en), 0);
    check("rst_data", 32'(bus.lcd_data), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);

    release_and_init();

    for (int it = 0; it < 9; it++) begin
      if (it > 0) begin
        for (int i = 0; i < 32; i++) begin
          phrase[i] = 8'($urandom);
          if ($urandom_range(0, 7) == 0) phrase[i] = 8'h00;
        end
      end
      run_refresh(it % 3, (it == 1) ? 6 : int'($urandom_range(1, 33)));
    end

    for (int i = 0; i < 16; i++) begin
      phrase[i]      = s1[i];
      phrase[16 + i] = s2[i];
    end
    reset_mid();
    release_and_init();
    run_refresh(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
